// File: rtl/usb_protocol_controller_pkg.sv
// Shared types for the USB bulk-endpoint transaction controller.
// Packet codes, FSM state encoding and buffer-occupancy width.
package usb_pc_pkg;

  localparam int OCC_W = 7;

  typedef enum logic [2:0] {
    RX_NONE      = 3'b000,
    RX_IN        = 3'b001,
    RX_OUT       = 3'b010,
    RX_ACK       = 3'b011,
    RX_ERR       = 3'b100,
    RX_DATA_DONE = 3'b101,
    RX_NAK       = 3'b110,
    RX_NONE_ALT  = 3'b111
  } rx_packet_t;

  typedef enum logic [1:0] {
    TX_NONE = 2'b00,
    TX_DATA = 2'b01,
    TX_NAK  = 2'b10,
    TX_ACK  = 2'b11
  } tx_packet_t;

  // ST_SPARE is never entered; it exists so an upset encoding recovers to IDLE.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_RESERVED = 4'd1,
    ST_IN_WAIT  = 4'd2,
    ST_IN_MODE  = 4'd3,
    ST_IN_NAK   = 4'd4,
    ST_OUT_MODE = 4'd5,
    ST_OUT_WAIT = 4'd6,
    ST_OUT_ACK  = 4'd7,
    ST_OUT_NAK  = 4'd8,
    ST_SPARE    = 4'd9
  } pc_state_t;

endpackage

// File: rtl/usb_protocol_controller_if.sv
// Buffer-status / packet-event bundle between the packet engines and the controller.
// slave = controller side, master = surrounding RX/TX/AHB logic.
interface usb_protocol_controller_if;
  import usb_pc_pkg::*;

  logic [OCC_W-1:0] Buffer_Occupancy;
  logic [OCC_W-1:0] TX_Packet_Data_Size;
  logic             Buffer_Reserved;
  rx_packet_t       RX_Packet;
  logic             RX_Error;
  logic             RX_Transfer_Active;
  logic             RX_Data_Ready;
  logic             TX_Transfer_Active;
  logic             TX_Error;
  logic             D_Mode;
  tx_packet_t       TX_Packet;
  logic             clear;

  modport slave (
    input  Buffer_Occupancy, TX_Packet_Data_Size, Buffer_Reserved, RX_Packet,
    output RX_Error, RX_Transfer_Active, RX_Data_Ready, TX_Transfer_Active,
           TX_Error, D_Mode, TX_Packet, clear
  );

  modport master (
    output Buffer_Occupancy, TX_Packet_Data_Size, Buffer_Reserved, RX_Packet,
    input  RX_Error, RX_Transfer_Active, RX_Data_Ready, TX_Transfer_Active,
           TX_Error, D_Mode, TX_Packet, clear
  );
endinterface

// File: rtl/usb_protocol_controller_timeout.sv
// Idle-bus watchdog for the data-phase states; built only with PC_TIMEOUT_EN.
// Counts while 'count' is high, clears on 'restart', saturates at LIMIT.
module pc_timeout_counter #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic count,
  input  logic restart,
  output logic expire
);
  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  assign expire = (cnt == W'(LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   cnt <= '0;
    else if (restart || !count) cnt <= '0;
    else if (!expire)          cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/usb_protocol_controller.sv
// Bulk-endpoint transaction FSM: decodes host tokens/handshakes against buffer state.
// Optional watchdog on data-phase states enabled by defining PC_TIMEOUT_EN.
module usb_protocol_controller
  import usb_pc_pkg::*;
(
  input  logic                     clk,
  input  logic                     n_rst,
  usb_protocol_controller_if.slave bus
);
`ifdef PC_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 1024;
`endif

  pc_state_t state, nxt;
  logic      is_in, is_out, is_ack, is_err, is_done, is_nak;
  logic      occ_zero, size_match, expire;

  assign is_in   = (bus.RX_Packet == RX_IN);
  assign is_out  = (bus.RX_Packet == RX_OUT);
  assign is_ack  = (bus.RX_Packet == RX_ACK);
  assign is_err  = (bus.RX_Packet == RX_ERR);
  assign is_done = (bus.RX_Packet == RX_DATA_DONE);
  assign is_nak  = (bus.RX_Packet == RX_NAK);

  assign occ_zero   = (bus.Buffer_Occupancy == '0);
  assign size_match = (bus.Buffer_Occupancy == bus.TX_Packet_Data_Size) &&
                      (bus.TX_Packet_Data_Size != '0);

`ifdef PC_TIMEOUT_EN
  logic any_pkt, timed_state;
  assign any_pkt     = (bus.RX_Packet != RX_NONE) && (bus.RX_Packet != RX_NONE_ALT);
  assign timed_state = (state == ST_OUT_MODE) || (state == ST_OUT_WAIT) ||
                       (state == ST_IN_MODE);

  pc_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .rst    (n_rst),
    .count  (timed_state),
    .restart(any_pkt),
    .expire (expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) state <= ST_IDLE;
    else       state <= nxt;
  end

  // Tokens take priority over buffer-ownership changes in IDLE/RESERVED.
  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (is_out)                    nxt = occ_zero ? ST_OUT_MODE : ST_OUT_WAIT;
        else if (is_in)                nxt = ST_IN_NAK;
        else if (bus.Buffer_Reserved)  nxt = ST_RESERVED;
      end
      ST_RESERVED: begin
        if (is_out)                    nxt = ST_OUT_WAIT;
        else if (is_in)                nxt = ST_IN_NAK;
        else if (!bus.Buffer_Reserved) nxt = size_match ? ST_IN_WAIT : ST_IDLE;
      end
      ST_IN_WAIT: begin
        if (is_in)       nxt = ST_IN_MODE;
        else if (is_out) nxt = ST_OUT_WAIT;
      end
      ST_IN_MODE: begin
        if (is_ack)      nxt = ST_IDLE;
        else if (is_nak) nxt = ST_IN_NAK;
        else if (expire) nxt = ST_IN_NAK;
      end
      ST_OUT_MODE: begin
        if (is_done)     nxt = ST_OUT_ACK;
        else if (is_err) nxt = ST_OUT_WAIT;
        else if (expire) nxt = ST_OUT_NAK;
      end
      ST_OUT_WAIT: begin
        if (is_done)     nxt = ST_OUT_NAK;
        else if (expire) nxt = ST_OUT_NAK;
      end
      ST_OUT_ACK, ST_OUT_NAK, ST_IN_NAK: nxt = ST_IDLE;
      default:                           nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.RX_Error           = 1'b0;
    bus.RX_Transfer_Active = 1'b0;
    bus.RX_Data_Ready      = 1'b0;
    bus.TX_Transfer_Active = 1'b0;
    bus.TX_Error           = 1'b0;
    bus.D_Mode             = 1'b0;
    bus.TX_Packet          = TX_NONE;
    bus.clear              = 1'b0;
    case (state)
      ST_OUT_MODE: begin
        bus.D_Mode             = 1'b1;
        bus.RX_Transfer_Active = 1'b1;
      end
      ST_OUT_WAIT: begin
        bus.D_Mode             = 1'b1;
        bus.RX_Transfer_Active = 1'b1;
        bus.clear              = 1'b1;
      end
      ST_OUT_ACK: begin
        bus.RX_Data_Ready = 1'b1;
        bus.TX_Packet     = TX_ACK;
      end
      ST_OUT_NAK: begin
        bus.RX_Error  = 1'b1;
        bus.clear     = 1'b1;
        bus.TX_Packet = TX_NAK;
      end
      ST_IN_MODE: begin
        bus.TX_Transfer_Active = 1'b1;
        bus.TX_Packet          = TX_DATA;
      end
      ST_IN_NAK: begin
        bus.TX_Error  = 1'b1;
        bus.clear     = 1'b1;
        bus.TX_Packet = TX_NAK;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_usb_protocol_controller.sv
// Directed bench for usb_protocol_controller: each step drives inputs, clocks once,
// and compares the packed output word against a hand-computed constant.
module tb_usb_protocol_controller;
  import usb_pc_pkg::*;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  usb_protocol_controller_if bus ();

  usb_protocol_controller dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  // {RX_Error, RX_Transfer_Active, RX_Data_Ready, TX_Transfer_Active, TX_Error, D_Mode, TX_Packet[1:0], clear}
  logic [8:0] outs;
  assign outs = {bus.RX_Error, bus.RX_Transfer_Active, bus.RX_Data_Ready, bus.TX_Transfer_Active,
                 bus.TX_Error, bus.D_Mode, bus.TX_Packet, bus.clear};

  localparam logic [8:0] O_ZERO     = 9'b0_0_0_0_0_0_00_0;
  localparam logic [8:0] O_OUT_MODE = 9'b0_1_0_0_0_1_00_0;
  localparam logic [8:0] O_OUT_WAIT = 9'b0_1_0_0_0_1_00_1;
  localparam logic [8:0] O_OUT_ACK  = 9'b0_0_1_0_0_0_11_0;
  localparam logic [8:0] O_OUT_NAK  = 9'b1_0_0_0_0_0_10_1;
  localparam logic [8:0] O_IN_MODE  = 9'b0_0_0_1_0_0_01_0;
  localparam logic [8:0] O_IN_NAK   = 9'b0_0_0_0_1_0_10_1;

  task automatic chk(input string tag, input logic [8:0] exp);
    checks++;
    assert (outs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, outs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.Buffer_Occupancy    = '0;
    bus.TX_Packet_Data_Size = '0;
    bus.Buffer_Reserved     = 1'b0;
    bus.RX_Packet           = RX_NONE;

    // 1. reset
    step(); step();
    chk("reset_held", O_ZERO);
    n_rst = 1'b0;
    step();
    chk("reset_release", O_ZERO);

    // 2. OUT accepted
    bus.RX_Packet = RX_OUT;       step(); chk("out_mode", O_OUT_MODE);
    bus.RX_Packet = RX_NONE;      step(); chk("out_mode_hold", O_OUT_MODE);
    bus.Buffer_Occupancy = 7'd5;
    bus.RX_Packet = RX_DATA_DONE; step(); chk("out_ack", O_OUT_ACK);
    bus.RX_Packet = RX_NONE;      step(); chk("out_ack_to_idle", O_ZERO);

    // 111 is NONE in IDLE
    bus.RX_Packet = RX_NONE_ALT;  step(); chk("rx111_idle", O_ZERO);

    // 3. IN path at full 64-byte buffer
    bus.RX_Packet = RX_NONE;
    bus.Buffer_Reserved = 1'b1;   step(); chk("reserved", O_ZERO);
    bus.Buffer_Reserved = 1'b0;
    bus.Buffer_Occupancy = 7'd64;
    bus.TX_Packet_Data_Size = 7'd64; step(); chk("in_wait", O_ZERO);
    bus.RX_Packet = RX_IN;        step(); chk("in_mode", O_IN_MODE);
    bus.RX_Packet = RX_NONE;      step(); chk("in_mode_hold", O_IN_MODE);
    bus.RX_Packet = RX_ACK;       step(); chk("in_ack_idle", O_ZERO);

    // 4. OUT refused (occupancy 1), RX_ERR holds in OUT_WAIT
    bus.Buffer_Occupancy = 7'd1;
    bus.RX_Packet = RX_OUT;       step(); chk("out_wait", O_OUT_WAIT);
    bus.RX_Packet = RX_ERR;       step(); chk("out_wait_err_hold", O_OUT_WAIT);
    bus.RX_Packet = RX_DATA_DONE; step(); chk("out_nak", O_OUT_NAK);
    bus.RX_Packet = RX_NONE;      step(); chk("out_nak_to_idle", O_ZERO);
    // via OUT_MODE then RX_ERR
    bus.Buffer_Occupancy = 7'd0;
    bus.RX_Packet = RX_OUT;       step(); chk("out_mode2", O_OUT_MODE);
    bus.RX_Packet = RX_ERR;       step(); chk("out_mode_err", O_OUT_WAIT);
    bus.RX_Packet = RX_DATA_DONE; step(); chk("out_nak2", O_OUT_NAK);
    bus.RX_Packet = RX_NONE;      step(); chk("out_nak2_idle", O_ZERO);

    // 5. IN refused: IDLE (token beats Buffer_Reserved), RESERVED, IN_MODE+NAK
    bus.Buffer_Reserved = 1'b1;
    bus.RX_Packet = RX_IN;        step(); chk("in_nak_idle", O_IN_NAK);
    bus.Buffer_Reserved = 1'b0;
    bus.RX_Packet = RX_NONE;      step(); chk("in_nak_idle_exit", O_ZERO);
    bus.Buffer_Occupancy = 7'd1;
    bus.Buffer_Reserved = 1'b1;   step(); chk("reserved2", O_ZERO);
    bus.RX_Packet = RX_IN;        step(); chk("in_nak_reserved", O_IN_NAK);
    bus.RX_Packet = RX_NONE;
    bus.Buffer_Reserved = 1'b0;   step(); chk("in_nak_reserved_exit", O_ZERO);
    bus.Buffer_Reserved = 1'b1;   step(); chk("reserved3", O_ZERO);
    bus.Buffer_Reserved = 1'b0;
    bus.TX_Packet_Data_Size = 7'd1; step(); chk("in_wait2", O_ZERO);
    bus.RX_Packet = RX_IN;        step(); chk("in_mode2", O_IN_MODE);
    bus.RX_Packet = RX_NAK;       step(); chk("in_mode_nak", O_IN_NAK);
    bus.RX_Packet = RX_NONE;      step(); chk("in_mode_nak_exit", O_ZERO);

    // size==0 with occ==0 must not reach IN_WAIT: IN afterwards is NAKed from IDLE
    bus.Buffer_Occupancy = 7'd0;
    bus.TX_Packet_Data_Size = 7'd0;
    bus.Buffer_Reserved = 1'b1;   step();
    bus.Buffer_Reserved = 1'b0;   step();
    bus.RX_Packet = RX_IN;        step(); chk("size0_not_in_wait", O_IN_NAK);
    bus.RX_Packet = RX_NONE;      step();
    // occ != size (full-width compare) also falls back to IDLE
    bus.Buffer_Occupancy = 7'd64;
    bus.TX_Packet_Data_Size = 7'd63;
    bus.Buffer_Reserved = 1'b1;   step();
    bus.Buffer_Reserved = 1'b0;   step();
    bus.RX_Packet = RX_IN;        step(); chk("size_mismatch_idle", O_IN_NAK);
    bus.RX_Packet = RX_NONE;      step();

    // 6. OUT from RESERVED and from IN_WAIT
    bus.Buffer_Reserved = 1'b1;   step(); chk("reserved4", O_ZERO);
    bus.RX_Packet = RX_OUT;       step(); chk("reserved_out", O_OUT_WAIT);
    bus.Buffer_Reserved = 1'b0;
    bus.RX_Packet = RX_DATA_DONE; step(); chk("reserved_out_nak", O_OUT_NAK);
    bus.RX_Packet = RX_NONE;      step();
    bus.TX_Packet_Data_Size = 7'd64;
    bus.Buffer_Reserved = 1'b1;   step();
    bus.Buffer_Reserved = 1'b0;   step(); chk("in_wait3", O_ZERO);
    bus.RX_Packet = RX_OUT;       step(); chk("in_wait_out", O_OUT_WAIT);
    bus.RX_Packet = RX_DATA_DONE; step();
    bus.RX_Packet = RX_NONE;      step(); chk("back_idle", O_ZERO);

    // asynchronous reset mid-transfer, no clock edge in between
    bus.Buffer_Occupancy = 7'd0;
    bus.RX_Packet = RX_OUT;       step(); chk("pre_reset_out_mode", O_OUT_MODE);
    bus.RX_Packet = RX_NONE;
    n_rst = 1'b1;
    #1;
    chk("async_reset", O_ZERO);
    n_rst = 1'b0;
    step(); chk("post_reset_idle", O_ZERO);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
